// File: rtl/popcount_ternary_acc.sv
// Sequential ternary neuron: accumulates popcount(pos) - popcount(neg) over BEATS
// beats (optionally LSB-truncated per beat) and thresholds the sum to {-1,0,+1}.
module popcount_ternary_acc #(
  parameter int WIDTH      = 27,
  parameter int BEATS      = 4,
  parameter int APPROX_LSB = 2,
  parameter int THR_HI     = 8,
  parameter int THR_LO     = -8,
  localparam int SUM_W     = $clog2(WIDTH*BEATS+1)+1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_pos,
  input  logic [WIDTH-1:0]        in_neg,
  input  logic                    approx_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [SUM_W-1:0] out_sum,
  output logic [1:0]              out_act
);

  localparam int CNT_W  = $clog2(WIDTH+1);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0]       LAST_BEAT = BEAT_W'(BEATS-1);
  localparam logic signed [SUM_W-1:0] THR_HI_S  = SUM_W'(THR_HI);
  localparam logic signed [SUM_W-1:0] THR_LO_S  = SUM_W'(THR_LO);

  typedef enum logic [1:0] {S_ACC, S_DRAIN, S_OUT} state_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] trunc_lsb(input logic [CNT_W-1:0] c, input logic en);
    logic [CNT_W-1:0] mask;
    mask = '1;
    mask = mask << APPROX_LSB;
    return en ? (c & mask) : c;
  endfunction

  function automatic logic [1:0] ternary(input logic signed [SUM_W-1:0] s);
    if (s >= THR_HI_S) return 2'b01;
    if (s <= THR_LO_S) return 2'b11;
    return 2'b00;
  endfunction

  state_t                    state_q, state_d;
  logic [BEAT_W-1:0]         beat_cnt;
  logic                      mode_q;
  logic                      accept;
  logic                      last_beat;
  logic                      use_approx;
  logic [CNT_W-1:0]          pc_pos_p0, pc_neg_p0;
  logic signed [SUM_W-1:0]   d_p0;
  logic signed [SUM_W-1:0]   d_p1;
  logic                      vld_p1;
  logic signed [SUM_W-1:0]   acc_p2;
  logic signed [SUM_W-1:0]   acc_sum;
  logic [1:0]                act_p2;

  assign accept    = in_valid && in_ready;
  assign last_beat = (beat_cnt == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_ACC;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_ACC: begin
        in_ready = 1'b1;
        if (in_valid && last_beat) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_ACC;
      end
      default: state_d = S_ACC;
    endcase
  end

  // Stage 0: exact popcounts, truncated when approximate mode applies to this beat
  assign use_approx = (beat_cnt == '0) ? approx_en : mode_q;
  assign pc_pos_p0  = trunc_lsb(popcount(in_pos), use_approx);
  assign pc_neg_p0  = trunc_lsb(popcount(in_neg), use_approx);
  assign d_p0       = $signed(SUM_W'(pc_pos_p0)) - $signed(SUM_W'(pc_neg_p0));

  // Stage 1: per-beat difference register
  always_ff @(posedge clk) begin
    if (accept) d_p1 <= d_p0;
  end

  // Stage 2: accumulator, fed by stage 1; the DRAIN cycle folds in the last beat
  assign acc_sum = acc_p2 + d_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      mode_q   <= 1'b0;
      vld_p1   <= 1'b0;
      acc_p2   <= '0;
      act_p2   <= 2'b00;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
        if (beat_cnt == '0) mode_q <= approx_en;
      end
      if (vld_p1) acc_p2 <= acc_sum;
      else if (state_q == S_OUT && out_ready) acc_p2 <= '0;
      if (state_q == S_DRAIN) act_p2 <= ternary(acc_sum);
      else if (state_q == S_OUT && out_ready) act_p2 <= 2'b00;
    end
  end

  assign out_sum = acc_p2;
  assign out_act = act_p2;

endmodule

// File: tb/tb_popcount_ternary_acc.sv
// Bench for popcount_ternary_acc: directed table, multi-cycle corner sequences,
// and randomized vectors checked against an arithmetic reference model.
module tb_popcount_ternary_acc;

  localparam int WIDTH      = 27;
  localparam int BEATS      = 4;
  localparam int APPROX_LSB = 2;
  localparam int THR_HI     = 8;
  localparam int THR_LO     = -8;
  localparam int SUM_W      = $clog2(WIDTH*BEATS+1)+1;

  typedef logic [BEATS-1:0][WIDTH-1:0] vec_t;
  typedef struct {
    string            nm;
    vec_t             pos;
    vec_t             neg;
    logic [BEATS-1:0] ap;
    int               exp_sum;
    logic [1:0]       exp_act;
  } tc_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        in_pos;
  logic [WIDTH-1:0]        in_neg;
  logic                    approx_en;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [SUM_W-1:0] out_sum;
  logic [1:0]              out_act;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  popcount_ternary_acc #(
    .WIDTH(WIDTH), .BEATS(BEATS), .APPROX_LSB(APPROX_LSB),
    .THR_HI(THR_HI), .THR_LO(THR_LO)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pos(in_pos), .in_neg(in_neg), .approx_en(approx_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_act(out_act)
  );

  function automatic int ref_sum(input vec_t p, input vec_t n, input logic ap0);
    int s, cp, cn, q;
    s = 0;
    q = 1 << APPROX_LSB;
    for (int b = 0; b < BEATS; b++) begin
      cp = $countones(p[b]);
      cn = $countones(n[b]);
      if (ap0) begin
        cp = (cp / q) * q;
        cn = (cn / q) * q;
      end
      s += cp - cn;
    end
    return s;
  endfunction

  function automatic logic [1:0] ref_act(input int s);
    if (s >= THR_HI) return 2'b01;
    if (s <= THR_LO) return 2'b11;
    return 2'b00;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send_beat(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] n,
                           input logic ap, input string nm);
    int k;
    in_pos    = p;
    in_neg    = n;
    approx_en = ap;
    in_valid  = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    if (!in_ready) check({nm, "_ready_timeout"}, 0, 1);
    tick();
    in_valid  = 1'b0;
    in_pos    = WIDTH'($urandom);
    in_neg    = WIDTH'($urandom);
    approx_en = 1'($urandom_range(0, 1));
  endtask

  task automatic run_vector(input vec_t p, input vec_t n, input logic [BEATS-1:0] ap,
                            input int max_gap, input int stall, input int exp_sum,
                            input logic [1:0] exp_act, input string nm, input bit chk_lat);
    int k;
    for (int b = 0; b < BEATS; b++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
      send_beat(p[b], n[b], ap[b], nm);
    end
    if (chk_lat) begin
      check({nm, "_lat_drain"}, int'(out_valid), 0);
      tick();
      check({nm, "_lat_out"}, int'(out_valid), 1);
    end
    k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    if (!out_valid) check({nm, "_out_timeout"}, 0, 1);
    check({nm, "_sum"}, int'(out_sum), exp_sum);
    check({nm, "_act"}, int'(out_act), int'(exp_act));
    for (int s = 0; s < stall; s++) begin
      tick();
      check({nm, "_hold_valid"}, int'(out_valid), 1);
      check({nm, "_hold_sum"}, int'(out_sum), exp_sum);
      check({nm, "_hold_act"}, int'(out_act), int'(exp_act));
      check({nm, "_hold_in_ready"}, int'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({nm, "_release_valid"}, int'(out_valid), 0);
    check({nm, "_release_in_ready"}, int'(in_ready), 1);
  endtask

  tc_t  tbl [8];
  vec_t rp, rn;
  logic [BEATS-1:0] rap;
  int   rs;

  initial begin
    tbl[0] = '{"all_pos",    {BEATS{27'h7FFFFFF}}, {BEATS{27'h0}},        4'b0000,  108, 2'b01};
    tbl[1] = '{"all_neg",    {BEATS{27'h0}},        {BEATS{27'h7FFFFFF}}, 4'b0000, -108, 2'b11};
    tbl[2] = '{"approx_on",  {BEATS{27'h7F}},       {BEATS{27'h1F}},      4'b0001,    0, 2'b00};
    tbl[3] = '{"approx_off", {BEATS{27'h7F}},       {BEATS{27'h1F}},      4'b0000,    8, 2'b01};
    tbl[4] = '{"approx_late",{BEATS{27'h7F}},       {BEATS{27'h1F}},      4'b1110,    8, 2'b01};
    tbl[5] = '{"below_hi",   {27'h1, 27'h1, 27'h3, 27'h7}, {BEATS{27'h0}}, 4'b0000,   7, 2'b00};
    tbl[6] = '{"at_lo",      {BEATS{27'h0}},        {BEATS{27'h3}},       4'b0000,   -8, 2'b11};
    tbl[7] = '{"above_lo",   {BEATS{27'h0}}, {27'h1, 27'h1, 27'h3, 27'h7}, 4'b0000,  -7, 2'b00};

    rst = 1'b0; in_valid = 1'b0; in_pos = '0; in_neg = '0;
    approx_en = 1'b0; out_ready = 1'b0;
    do_reset();
    check("reset_in_ready",  int'(in_ready),  1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_sum",   int'(out_sum),   0);
    check("reset_out_act",   int'(out_act),   0);

    for (int i = 0; i < 8; i++)
      run_vector(tbl[i].pos, tbl[i].neg, tbl[i].ap, i % 3, 0,
                 tbl[i].exp_sum, tbl[i].exp_act, tbl[i].nm, 1'b1);

    // Result held under backpressure
    run_vector({BEATS{27'h7FFFFFF}}, {BEATS{27'h0}}, 4'b0000, 0, 5, 108, 2'b01,
               "backpressure", 1'b1);

    // Reset after two beats leaves no residue
    send_beat(27'h7FFFFFF, 27'h0, 1'b0, "abort");
    send_beat(27'h7FFFFFF, 27'h0, 1'b0, "abort");
    do_reset();
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_in_ready",  int'(in_ready),  1);
    check("abort_out_sum",   int'(out_sum),   0);
    run_vector({BEATS{27'h7}}, {BEATS{27'h0}}, 4'b0000, 0, 0, 12, 2'b01,
               "after_abort", 1'b1);

    for (int v = 0; v < 200; v++) begin
      for (int b = 0; b < BEATS; b++) begin
        rp[b] = WIDTH'($urandom);
        rn[b] = WIDTH'($urandom);
        if ($urandom_range(0, 1) == 1) rp[b] = rp[b] & WIDTH'($urandom);
        if ($urandom_range(0, 1) == 1) rn[b] = rn[b] & WIDTH'($urandom);
        if ($urandom_range(0, 3) == 0) rn[b] = rn[b] & WIDTH'($urandom) & WIDTH'($urandom);
      end
      rap = BEATS'($urandom);
      rs  = ref_sum(rp, rn, rap[0]);
      run_vector(rp, rn, rap, 2, $urandom_range(0, 3), rs, ref_act(rs), "rand", 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
